// File: rtl/dll_fetch_if.sv
// Memory/bus handshake between the DLL fetch engine and the memory arbiter.
//   mem_req  : read request from the fetch engine
//   AB_out   : read address, valid while mem_req is high
//   mem_ack  : read completes this cycle, DB_in valid in the same cycle
//   DB_in    : read data
//   drive_AB : fetch engine owns the address bus
//   halt_b   : active-low CPU halt
interface dll_fetch_if;
  logic        mem_req;
  logic [15:0] AB_out;
  logic        mem_ack;
  logic [7:0]  DB_in;
  logic        drive_AB;
  logic        halt_b;

  modport master (output mem_req, AB_out, drive_AB, halt_b,
                  input  mem_ack, DB_in);
  modport slave  (input  mem_req, AB_out, drive_AB, halt_b,
                  output mem_ack, DB_in);
endinterface

// File: rtl/dll_fetch.sv
// MARIA display-list-list fetch engine. Takes the bus, reads 3-byte DLL
// entries starting at ZP, presents each decoded entry to the line renderer,
// advances on zone boundaries and restarts from ZP on every frame start.
//   sysclock, reset_b   : clock, async active-low reset
//   ZP, zp_written      : DLL base pointer and its "programmed" level
//   frame_start         : pulse, restart from ZP
//   next_zone           : pulse, fetch the next entry (only honoured in HOLD)
//   bus                 : memory request/ack, address, data, bus ownership
//   entry_valid         : one-cycle pulse, entry fields updated
//   dli/h16/h8/zone_offset/dl_ptr : decoded entry fields
//   busy                : high in F0/F1/F2
//
// state | meaning
// IDLE  | no valid ZP yet or never started; waiting for frame_start
// F0    | reading entry byte 0 at ptr
// F1    | reading entry byte 1 at ptr+1
// F2    | reading entry byte 2 at ptr+2
// HOLD  | entry presented; waiting for next_zone or frame_start
module dll_fetch #(
  parameter int ENTRY_BYTES = 3
) (
  input  logic        sysclock,
  input  logic        reset_b,
  input  logic [15:0] ZP,
  input  logic        zp_written,
  input  logic        frame_start,
  input  logic        next_zone,
  dll_fetch_if.master bus,
  output logic        entry_valid,
  output logic        dli,
  output logic        h16,
  output logic        h8,
  output logic [3:0]  zone_offset,
  output logic [15:0] dl_ptr,
  output logic        busy
);

  typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_F2, S_HOLD} state_t;

  state_t      state;
  logic [15:0] ptr;
  logic        restart;
  logic [2:0]  sh_flags;   // byte0[7:5]; byte0[4] is never used
  logic [3:0]  sh_zone;    // byte0[3:0]
  logic [7:0]  sh_hi;      // byte1

  logic start;
  logic restart_now;

  assign start       = frame_start & zp_written;
  // A start arriving on the ack cycle itself still aborts this entry.
  assign restart_now = restart | start;

  always_ff @(posedge sysclock or negedge reset_b) begin
    if (!reset_b) begin
      state        <= S_IDLE;
      ptr          <= 16'h0000;
      restart      <= 1'b0;
      sh_flags     <= 3'b000;
      sh_zone      <= 4'h0;
      sh_hi        <= 8'h00;
      bus.mem_req  <= 1'b0;
      bus.AB_out   <= 16'h0000;
      bus.drive_AB <= 1'b0;
      bus.halt_b   <= 1'b1;
      busy         <= 1'b0;
      entry_valid  <= 1'b0;
      dli          <= 1'b0;
      h16          <= 1'b0;
      h8           <= 1'b0;
      zone_offset  <= 4'h0;
      dl_ptr       <= 16'h0000;
    end else begin
      entry_valid <= 1'b0;
      case (state)
        S_IDLE, S_HOLD: begin
          if (start || (state == S_HOLD && next_zone)) begin
            state        <= S_F0;
            bus.mem_req  <= 1'b1;
            bus.drive_AB <= 1'b1;
            bus.halt_b   <= 1'b0;
            busy         <= 1'b1;
            if (start) begin
              ptr        <= ZP;
              bus.AB_out <= ZP;
            end else begin
              bus.AB_out <= ptr;
            end
          end
        end
        S_F0, S_F1, S_F2: begin
          if (bus.mem_ack) begin
            if (restart_now) begin
              // Aborted entry: drop the data and refetch from ZP.
              state      <= S_F0;
              ptr        <= ZP;
              bus.AB_out <= ZP;
              restart    <= 1'b0;
            end else begin
              case (state)
                S_F0: begin
                  sh_flags   <= bus.DB_in[7:5];
                  sh_zone    <= bus.DB_in[3:0];
                  bus.AB_out <= ptr + 16'd1;
                  state      <= S_F1;
                end
                S_F1: begin
                  sh_hi      <= bus.DB_in;
                  bus.AB_out <= ptr + 16'd2;
                  state      <= S_F2;
                end
                default: begin
                  // Byte 2 goes straight to dl_ptr, no shadow needed.
                  dli          <= sh_flags[2];
                  h16          <= sh_flags[1];
                  h8           <= sh_flags[0];
                  zone_offset  <= sh_zone;
                  dl_ptr       <= {sh_hi, bus.DB_in};
                  entry_valid  <= 1'b1;
                  ptr          <= ptr + 16'(ENTRY_BYTES);
                  state        <= S_HOLD;
                  bus.mem_req  <= 1'b0;
                  bus.drive_AB <= 1'b0;
                  bus.halt_b   <= 1'b1;
                  busy         <= 1'b0;
                end
              endcase
            end
          end else if (start) begin
            restart <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dll_fetch.sv
// Self-checking bench for dll_fetch: random memory image, a memory responder
// with configurable wait states, and scoreboards of expected read addresses
// and expected decoded entries built from a simple pointer model.
module tb_dll_fetch;

  typedef struct {
    bit        dli;
    bit        h16;
    bit        h8;
    bit [3:0]  zo;
    bit [15:0] dl;
  } entry_t;

  logic        sysclock;
  logic        reset_b;
  logic [15:0] ZP;
  logic        zp_written;
  logic        frame_start;
  logic        next_zone;
  logic        entry_valid;
  logic        dli;
  logic        h16;
  logic        h8;
  logic [3:0]  zone_offset;
  logic [15:0] dl_ptr;
  logic        busy;

  dll_fetch_if bus ();

  dll_fetch #(.ENTRY_BYTES(3)) dut (
    .sysclock    (sysclock),
    .reset_b     (reset_b),
    .ZP          (ZP),
    .zp_written  (zp_written),
    .frame_start (frame_start),
    .next_zone   (next_zone),
    .bus         (bus),
    .entry_valid (entry_valid),
    .dli         (dli),
    .h16         (h16),
    .h8          (h8),
    .zone_offset (zone_offset),
    .dl_ptr      (dl_ptr),
    .busy        (busy)
  );

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] exp_addr [$];
  entry_t      exp_entry [$];
  logic [15:0] mp;           // model DLL pointer
  int          wait_min = 0;
  int          wait_max = 0;
  int          halt_cnt = 0;
  int          req_cnt = 0;

  initial begin
    sysclock = 1'b0;
    forever #5 sysclock = ~sysclock;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic entry_t make_entry(input logic [15:0] a);
    entry_t e;
    logic [7:0] b0, b1, b2;
    b0 = mem[a];
    b1 = mem[16'(a + 16'd1)];
    b2 = mem[16'(a + 16'd2)];
    e.dli = b0[7];
    e.h16 = b0[6];
    e.h8  = b0[5];
    e.zo  = b0[3:0];
    e.dl  = {b1, b2};
    return e;
  endfunction

  task automatic expect_fetch(input logic [15:0] base);
    for (int i = 0; i < 3; i++) exp_addr.push_back(16'(base + 16'(i)));
    exp_entry.push_back(make_entry(base));
    mp = 16'(base + 16'd3);
  endtask

  task automatic expect_abort(input logic [15:0] base, input int n);
    for (int i = 0; i < n; i++) exp_addr.push_back(16'(base + 16'(i)));
  endtask

  task automatic pulse(input bit fs, input bit nz);
    @(negedge sysclock);
    frame_start = fs;
    next_zone   = nz;
    @(negedge sysclock);
    frame_start = 1'b0;
    next_zone   = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge sysclock);
      #1;
      n++;
    end while ((busy || exp_addr.size() != 0 || exp_entry.size() != 0) && n < 400);
    checks++;
    if (busy || exp_addr.size() != 0 || exp_entry.size() != 0) begin
      failures++;
      $display("FAIL %s_done: timeout busy=%0d addr_left=%0d entries_left=%0d",
               tag, busy, exp_addr.size(), exp_entry.size());
    end
  endtask

  task automatic wait_addr(input logic [15:0] a);
    int n;
    n = 0;
    do begin
      @(negedge sysclock);
      n++;
    end while (!(bus.mem_req && bus.AB_out == a) && n < 100);
    checks++;
    if (!(bus.mem_req && bus.AB_out == a)) begin
      failures++;
      $display("FAIL wait_addr: got 0x%0h expected 0x%0h", bus.AB_out, a);
    end
  endtask

  // Memory responder and address scoreboard.
  initial begin
    int remaining;
    bit armed;
    armed = 1'b0;
    remaining = 0;
    bus.mem_ack = 1'b0;
    bus.DB_in = 8'h00;
    forever begin
      @(negedge sysclock);
      bus.mem_ack = 1'b0;
      if (reset_b && bus.mem_req) begin
        if (!armed) begin
          remaining = $urandom_range(wait_max, wait_min);
          armed = 1'b1;
        end
        if (remaining == 0) begin
          checks++;
          if (exp_addr.size() == 0) begin
            failures++;
            $display("FAIL addr: got 0x%0h expected none", bus.AB_out);
          end else begin
            logic [15:0] ea;
            ea = exp_addr.pop_front();
            if (bus.AB_out !== ea) begin
              failures++;
              $display("FAIL addr: got 0x%0h expected 0x%0h", bus.AB_out, ea);
            end
          end
          bus.DB_in = mem[bus.AB_out];
          bus.mem_ack = 1'b1;
          armed = 1'b0;
        end else begin
          remaining--;
        end
      end else begin
        armed = 1'b0;
      end
    end
  end

  // Entry scoreboard and bus-signal monitor.
  initial begin
    forever begin
      @(negedge sysclock);
      if (!bus.halt_b) halt_cnt++;
      if (bus.mem_req) req_cnt++;
      if (reset_b) begin
        checks++;
        if (bus.drive_AB !== busy || bus.halt_b !== ~busy || bus.mem_req !== busy) begin
          failures++;
          $display("FAIL bus_sig: got drive=%0d halt_b=%0d req=%0d busy=%0d",
                   bus.drive_AB, bus.halt_b, bus.mem_req, busy);
        end
      end
      if (entry_valid) begin
        checks++;
        if (exp_entry.size() == 0) begin
          failures++;
          $display("FAIL entry: got unexpected entry_valid dl_ptr=0x%0h", dl_ptr);
        end else begin
          entry_t e;
          e = exp_entry.pop_front();
          if (dli !== e.dli || h16 !== e.h16 || h8 !== e.h8 ||
              zone_offset !== e.zo || dl_ptr !== e.dl) begin
            failures++;
            $display("FAIL entry: got %0d%0d%0d zo=%0h dl=%0h expected %0d%0d%0d zo=%0h dl=%0h",
                     dli, h16, h8, zone_offset, dl_ptr, e.dli, e.h16, e.h8, e.zo, e.dl);
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    mem[16'h1820] = 8'hC7;
    mem[16'h1821] = 8'h40;
    mem[16'h1822] = 8'h10;
    reset_b = 1'b0;
    ZP = 16'h0000;
    zp_written = 1'b0;
    frame_start = 1'b0;
    next_zone = 1'b0;
    mp = 16'h0000;
    repeat (3) @(negedge sysclock);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_ab_out", 32'(bus.AB_out), 0);
    chk("rst_drive_ab", 32'(bus.drive_AB), 0);
    chk("rst_halt_b", 32'(bus.halt_b), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_entry_valid", 32'(entry_valid), 0);
    chk("rst_flags", 32'({dli, h16, h8}), 0);
    chk("rst_zone_offset", 32'(zone_offset), 0);
    chk("rst_dl_ptr", 32'(dl_ptr), 0);
    reset_b = 1'b1;
    repeat (2) @(negedge sysclock);

    // Zero-wait first entry.
    ZP = 16'h1820;
    zp_written = 1'b1;
    wait_min = 0;
    wait_max = 0;
    expect_fetch(16'h1820);
    halt_cnt = 0;
    pulse(1'b1, 1'b0);
    wait_done("first");
    chk("first_halt_cycles", 32'(halt_cnt), 3);
    chk("first_dli", 32'(dli), 1);
    chk("first_h16", 32'(h16), 1);
    chk("first_h8", 32'(h8), 0);
    chk("first_zone_offset", 32'(zone_offset), 7);
    chk("first_dl_ptr", 32'(dl_ptr), 32'h4010);

    // next_zone with two wait states per byte.
    wait_min = 2;
    wait_max = 2;
    expect_fetch(16'h1823);
    halt_cnt = 0;
    pulse(1'b0, 1'b1);
    wait_done("zone2");
    chk("zone2_halt_cycles", 32'(halt_cnt), 9);

    // Address wrap at the top of memory.
    wait_min = 0;
    wait_max = 2;
    ZP = 16'hFFFE;
    expect_fetch(16'hFFFE);
    pulse(1'b1, 1'b0);
    wait_done("wrap");
    expect_fetch(mp);
    pulse(1'b0, 1'b1);
    wait_done("wrap_next");

    // frame_start while F1 waits for its ack.
    wait_min = 3;
    wait_max = 3;
    ZP = 16'h3000;
    expect_abort(16'h3000, 2);
    expect_fetch(16'h2000);
    pulse(1'b1, 1'b0);
    wait_addr(16'h3001);
    ZP = 16'h2000;
    pulse(1'b1, 1'b0);
    wait_done("restart");

    // Start ignored without a programmed ZP.
    zp_written = 1'b0;
    ZP = 16'h7777;
    halt_cnt = 0;
    req_cnt = 0;
    pulse(1'b1, 1'b0);
    repeat (5) @(negedge sysclock);
    chk("nozp_req_cycles", 32'(req_cnt), 0);
    chk("nozp_halt_cycles", 32'(halt_cnt), 0);
    zp_written = 1'b1;
    wait_min = 0;
    wait_max = 1;
    expect_fetch(mp);
    pulse(1'b0, 1'b1);
    wait_done("nozp_next");

    // frame_start beats next_zone in HOLD.
    ZP = 16'h5555;
    expect_fetch(16'h5555);
    pulse(1'b1, 1'b1);
    wait_done("both");

    // Random walk through the DLL.
    for (int it = 0; it < 24; it++) begin
      wait_min = 0;
      wait_max = $urandom_range(3, 0);
      if ($urandom_range(2, 0) == 0) begin
        ZP = 16'($urandom);
        expect_fetch(ZP);
        pulse(1'b1, 1'b0);
      end else begin
        expect_fetch(mp);
        pulse(1'b0, 1'b1);
      end
      wait_done("rand");
    end

    // Asynchronous reset during F2.
    wait_min = 6;
    wait_max = 6;
    ZP = 16'h0A00;
    expect_abort(16'h0A00, 2);
    pulse(1'b1, 1'b0);
    wait_addr(16'h0A02);
    @(posedge sysclock);
    #2;
    reset_b = 1'b0;
    #1;
    chk("arst_mem_req", 32'(bus.mem_req), 0);
    chk("arst_halt_b", 32'(bus.halt_b), 1);
    chk("arst_drive_ab", 32'(bus.drive_AB), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_flags", 32'({dli, h16, h8}), 0);
    chk("arst_zone_offset", 32'(zone_offset), 0);
    chk("arst_dl_ptr", 32'(dl_ptr), 0);
    chk("arst_acks_consumed", 32'(exp_addr.size()), 0);
    exp_addr.delete();
    exp_entry.delete();
    mp = 16'h0000;
    repeat (2) @(negedge sysclock);
    reset_b = 1'b1;
    req_cnt = 0;
    pulse(1'b0, 1'b1);
    repeat (3) @(negedge sysclock);
    chk("arst_idle_busy", 32'(busy), 0);
    chk("arst_idle_nz_ignored", 32'(req_cnt), 0);
    wait_min = 0;
    wait_max = 0;
    ZP = 16'h1234;
    expect_fetch(16'h1234);
    pulse(1'b1, 1'b0);
    wait_done("post_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
